// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
// Holds the default operand width, the FSM state encoding and the
// divide-by-zero quotient pattern.
package div_pkg;

  localparam int WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Divide-by-zero returns an all-ones quotient; the fill bit lets any
  // WIDTH build replicate it, the full constant documents the default width.
  localparam logic                     DIV0_FILL     = 1'b1;
  localparam logic [WIDTH_DEFAULT-1:0] DIV0_QUOTIENT = {WIDTH_DEFAULT{DIV0_FILL}};

endpackage

// File: rtl/sequential_divider_if.sv
// Start/done handshake bundle of the sequential divider.
// master: controller side (drives start, dividend, divisor).
// slave : divider side (drives busy, done, quotient, remainder, div_by_zero).
interface sequential_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/div_step.sv
// One restoring division iteration, purely combinational.
// Ports:
//   rem_in  : current partial remainder (always < dsr)
//   bit_in  : next dividend bit shifted into the remainder
//   dsr     : divisor magnitude
//   rem_out : new partial remainder
//   q_bit   : quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             bit_in,
  input  logic [WIDTH-1:0] dsr,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);
  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_in, bit_in};
  // Because rem_in < dsr, the true difference lies in (-2^WIDTH, 2^WIDTH),
  // so bit WIDTH of a WIDTH+1 bit subtraction is an exact sign bit.
  assign diff    = shifted - {1'b0, dsr};
  assign q_bit   = ~diff[WIDTH];
  assign rem_out = q_bit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
endmodule

// File: rtl/sequential_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sequential_divider_if.slave (start/dividend/divisor in,
//              busy/done/quotient/remainder/div_by_zero out, all registered)
// Build option: define DIV_SIGNED_EN for two's-complement operands; left
// undefined the operands are unsigned and the sign logic is absent.
// Latency: done is high WIDTH+1 clocks after the accepting edge, 1 clock for
// a zero divisor. A start seen while done is high is taken on the next cycle.
module sequential_divider
  import div_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input logic                clk,
  input logic                rst,
  sequential_divider_if.slave bus
);
  localparam int            CW       = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  state_t           state;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] rem_acc;   // partial remainder
  logic [WIDTH-1:0] dvd_acc;   // dividend magnitude, quotient bits shift in at the bottom
  logic [WIDTH-1:0] dsr_mag;
  logic             dz;
  logic [WIDTH-1:0] step_rem;
  logic             step_q;
  logic [WIDTH-1:0] q_res;
  logic [WIDTH-1:0] r_res;
  logic             accept;

`ifdef DIV_SIGNED_EN
  logic sign_q;
  logic sign_r;

  // Most-negative input maps to 2^(WIDTH-1), which fits the unsigned result.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x);
    return x[WIDTH-1] ? -x : x;
  endfunction

  function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] x,
                                                  input logic             neg);
    return neg ? -x : x;
  endfunction
`endif

  // Back-to-back starts wait out the done cycle before being accepted.
  assign accept = (state == IDLE) && bus.start && !bus.done;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_acc),
    .bit_in  (dvd_acc[WIDTH-1]),
    .dsr     (dsr_mag),
    .rem_out (step_rem),
    .q_bit   (step_q)
  );

  always_comb begin
`ifdef DIV_SIGNED_EN
    q_res = apply_sign(dvd_acc, sign_q);
    r_res = apply_sign(rem_acc, sign_r);
`else
    q_res = dvd_acc;
    r_res = rem_acc;
`endif
  end

  // Datapath: operand capture on accept, one shift-subtract per CALC cycle.
  always_ff @(posedge clk) begin
    if (accept) begin
      rem_acc <= '0;
      dz      <= (bus.divisor == '0);
`ifdef DIV_SIGNED_EN
      // A zero divisor keeps the raw dividend so it can be returned unmodified.
      dvd_acc <= (bus.divisor == '0) ? bus.dividend : magnitude(bus.dividend);
      dsr_mag <= magnitude(bus.divisor);
      sign_q  <= bus.dividend[WIDTH-1] ^ bus.divisor[WIDTH-1];
      sign_r  <= bus.dividend[WIDTH-1];
`else
      dvd_acc <= bus.dividend;
      dsr_mag <= bus.divisor;
`endif
    end else if (state == CALC) begin
      rem_acc <= step_rem;
      dvd_acc <= {dvd_acc[WIDTH-2:0], step_q};
    end
  end

  // Control FSM with registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      count           <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            bus.busy <= 1'b1;
            count    <= CNT_LAST;
            state    <= (bus.divisor == '0) ? FIN : CALC;
          end
        end
        CALC: begin
          count <= count - CW'(1);
          if (count == '0) state <= FIN;
        end
        FIN: begin
          bus.busy        <= 1'b0;
          bus.done        <= 1'b1;
          bus.div_by_zero <= dz;
          bus.quotient    <= dz ? {WIDTH{DIV0_FILL}} : q_res;
          bus.remainder   <= dz ? dvd_acc : r_res;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sequential_divider.sv
// Directed bench for sequential_divider: table of operand/result records
// plus hand-written handshake and mid-calculation reset sequences.
// Expected values follow the DIV_SIGNED_EN setting of the build.
module tb_sequential_divider;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sequential_divider_if #(.WIDTH(W)) bus ();

  sequential_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [W-1:0] dvd;
    logic [W-1:0] dsr;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         dz;
    int           lat;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] q,
                     input logic [W-1:0] r, input logic dz, input int lat);
    vec_t v;
    v.dvd = a; v.dsr = b; v.q = q; v.r = r; v.dz = dz; v.lat = lat;
    vecs.push_back(v);
  endtask

  // Waits (bounded) for done after the accepting edge; 100 means it never came.
  task automatic wait_done(output int lat, output logic busy_held);
    lat       = 0;
    busy_held = 1'b1;
    do begin
      @(posedge clk);
      #1;
      lat++;
      if (!bus.done && !bus.busy) busy_held = 1'b0;
    end while (!bus.done && lat < 100);
  endtask

  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic dz, output int lat, output logic busy_after);
    logic held;
    @(negedge clk);
    bus.dividend = a;
    bus.divisor  = b;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    busy_after   = bus.busy;
    bus.start    = 1'b0;
    bus.dividend = ~a;      // changes after acceptance must not matter
    bus.divisor  = b + 1;
    wait_done(lat, held);
    q  = bus.quotient;
    r  = bus.remainder;
    dz = bus.div_by_zero;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] q, r;
    logic         dz, bsy, held, seen_done;
    int           lat;

    add(32'd100,        32'd7,          32'd14,         32'd2,          1'b0, 33);
    add(32'd7,          32'd100,        32'd0,          32'd7,          1'b0, 33);
    add(32'd0,          32'd5,          32'd0,          32'd0,          1'b0, 33);
    add(32'd1000000007, 32'd1000,       32'd1000000,    32'd7,          1'b0, 33);
    add(32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFF,   32'd0,          1'b0, 33);
    add(32'hFFFFFFFF,   32'hFFFFFFFF,   32'd1,          32'd0,          1'b0, 33);
    add(32'h12345678,   32'd0,          32'hFFFFFFFF,   32'h12345678,   1'b1, 1);
    add(32'h80000000,   32'd0,          32'hFFFFFFFF,   32'h80000000,   1'b1, 1);
`ifdef DIV_SIGNED_EN
    add(32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0, 33);
    add(32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0, 33);
    add(32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0, 33);
    add(32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0, 33);
    add(32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0, 33);
    add(32'hFFFFFFFF,   32'd2,          32'd0,          32'hFFFFFFFF,   1'b0, 33);
`else
    add(32'hFFFFFF9C,   32'd7,          32'h24924916,   32'd2,          1'b0, 33);
    add(32'd100,        32'hFFFFFFF9,   32'd0,          32'd100,        1'b0, 33);
    add(32'hFFFFFF9C,   32'hFFFFFFF9,   32'd0,          32'hFFFFFF9C,   1'b0, 33);
    add(32'h80000000,   32'hFFFFFFFF,   32'd0,          32'h80000000,   1'b0, 33);
    add(32'h80000000,   32'd2,          32'h40000000,   32'd0,          1'b0, 33);
    add(32'hFFFFFFFF,   32'd2,          32'h7FFFFFFF,   32'd1,          1'b0, 33);
`endif

    // Reset state
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", W'(bus.busy), '0);
    check("rst_done", W'(bus.done), '0);
    check("rst_quotient", bus.quotient, '0);
    check("rst_remainder", bus.remainder, '0);
    check("rst_div_by_zero", W'(bus.div_by_zero), '0);
    @(negedge clk);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < vecs.size(); i++) begin
      run_div(vecs[i].dvd, vecs[i].dsr, q, r, dz, lat, bsy);
      check($sformatf("v%0d_busy", i), W'(bsy), W'(1));
      check($sformatf("v%0d_latency", i), W'(lat), W'(vecs[i].lat));
      check($sformatf("v%0d_quotient", i), q, vecs[i].q);
      check($sformatf("v%0d_remainder", i), r, vecs[i].r);
      check($sformatf("v%0d_div_by_zero", i), W'(dz), W'(vecs[i].dz));
    end

    // Start held high: busy throughout, operands ignored while busy,
    // re-accept one cycle after the done pulse.
    @(negedge clk);
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    check("hs_busy_after_accept", W'(bus.busy), W'(1));
    bus.dividend = 32'd5;
    bus.divisor  = 32'd1;
    wait_done(lat, held);
    check("hs_latency", W'(lat), W'(33));
    check("hs_busy_held", W'(held), W'(1));
    check("hs_quotient", bus.quotient, 32'd14);
    check("hs_remainder", bus.remainder, 32'd2);
    @(posedge clk);
    #1;
    check("hs_not_accepted_on_done_busy", W'(bus.busy), '0);
    check("hs_done_single_pulse", W'(bus.done), '0);
    @(posedge clk);
    #1;
    check("hs_accepted_next_busy", W'(bus.busy), W'(1));
    bus.start = 1'b0;
    wait_done(lat, held);
    check("hs2_latency", W'(lat), W'(33));
    check("hs2_quotient", bus.quotient, 32'd5);
    check("hs2_remainder", bus.remainder, 32'd0);
    @(posedge clk);
    #1;

    // Reset during CALC
    @(negedge clk);
    bus.dividend = 32'd100;
    bus.divisor  = 32'd7;
    bus.start    = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check("mid_busy_before_rst", W'(bus.busy), W'(1));
    rst = 1'b1;
    #1;
    check("mid_rst_busy", W'(bus.busy), '0);
    check("mid_rst_done", W'(bus.done), '0);
    check("mid_rst_quotient", bus.quotient, '0);
    check("mid_rst_remainder", bus.remainder, '0);
    check("mid_rst_div_by_zero", W'(bus.div_by_zero), '0);
    @(negedge clk);
    rst       = 1'b0;
    seen_done = 1'b0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.done) seen_done = 1'b1;
    end
    check("mid_rst_no_done", W'(seen_done), '0);

    // Recovery after reset
    run_div(32'd100, 32'd7, q, r, dz, lat, bsy);
    check("post_rst_latency", W'(lat), W'(33));
    check("post_rst_quotient", q, 32'd14);
    check("post_rst_remainder", r, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/sequential_divider.md
Name: sequential_divider

Overview:
Multi-cycle signed integer divider, the inverse companion of the team's 32x32 signed multiplier. Computes quotient and remainder of WIDTH-bit two's-complement operands using a restoring shift-subtract algorithm, one quotient bit per clock. Sits beside the multiplier in the arithmetic unit. Uses a start/done handshake so a controller can issue one division at a time.

Parameters:
WIDTH, 32, operand/result width in bits (>= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  asynchronous active-high reset
start  input  1  request; sampled only when busy=0
dividend  input  WIDTH  numerator, two's complement; captured on the accepted start
divisor  input  WIDTH  denominator, two's complement; captured on the accepted start
busy  output  1  high from the cycle after an accepted start until done
done  output  1  one-cycle pulse; quotient/remainder/div_by_zero valid this cycle
quotient  output  WIDTH  result, truncated toward zero; held until next accepted start
remainder  output  WIDTH  result, same sign as dividend (or zero); held
div_by_zero  output  1  set with done when divisor==0; held with results

Behaviour:
- One clock (clk); reset asynchronous, active-high (rst). On rst: state IDLE; busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, iteration counter=0.
- States: IDLE, CALC, FIN.
- IDLE: start=1 -> latch |dividend|, |divisor|, sign_q = sign(dividend)^sign(divisor), sign_r = sign(dividend); clear partial remainder; counter=WIDTH-1; go to CALC; busy=1 next cycle.
- If divisor==0 at acceptance: skip CALC and go straight to FIN. Result: quotient = all ones, remainder = dividend unmodified, div_by_zero=1.
- CALC: each cycle, shift {partial remainder, dividend magnitude} left 1. Trial-subtract divisor magnitude in WIDTH+1 bits. If non-negative: keep the difference and set quotient bit=1; else restore and set the bit to 0. Counter decrements. At counter==0 go to FIN.
- FIN (one cycle): apply signs (negate quotient if sign_q, negate remainder if sign_r), register outputs, done=1, busy=0, return to IDLE.
- Latency: done asserts exactly WIDTH+1 cycles after the start-accept edge (normal path), 1 cycle (divide-by-zero path).
- Back-to-back: start may be high in the same cycle done is high. That start is not accepted (state is FIN); it is accepted on the next IDLE cycle.
- start while busy=1: ignored, and operand inputs are ignored.
- Overflow: most-negative / -1 gives quotient = most-negative (wraps), remainder=0, div_by_zero=0.
- Magnitude of the most-negative operand is taken as unsigned 2^(WIDTH-1). Internal magnitudes are WIDTH bits unsigned.
- rst mid-CALC: immediate return to IDLE with all outputs cleared; no done pulse.
- Outputs are registered only; no combinational path from inputs to outputs.

Optional Feature:
DIV_SIGNED_EN
- Defined: signed two's-complement behaviour as above.
- Undefined: operands are treated as unsigned; sign handling logic is removed; remainder is always non-negative; the overflow case does not exist. Divide-by-zero result is unchanged (quotient all ones, remainder = dividend). Latency is unchanged.

Decomposition:
- Package div_pkg holds:
  - default WIDTH constant
  - state enum (IDLE, CALC, FIN)
  - DIV0_QUOTIENT all-ones constant
- Sub-module div_step: purely combinational single restoring iteration.
  - Inputs: partial remainder, next dividend bit, divisor magnitude.
  - Outputs: new partial remainder, quotient bit.
  - Instantiated once inside the FSM datapath.

Test Plan:
1. Signed, in range: dividend=100, divisor=7 -> done at cycle 33 after accept; quotient=14, remainder=2, div_by_zero=0.
2. Negative operands: -100/7 -> q=-14 (0xFFFFFFF2), r=-2; 100/-7 -> q=-14, r=2; -100/-7 -> q=14, r=-2.
3. Divide by zero: 0x12345678/0 -> done 1 cycle after accept; q=0xFFFFFFFF, r=0x12345678, div_by_zero=1.
4. Overflow: 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, div_by_zero=0.
5. Handshake: start held high continuously.
   - busy=1 throughout CALC; start during busy is ignored.
   - New operation is accepted the cycle after the done pulse.
   - Assert rst at cycle 10 of a CALC: all outputs go to 0 immediately and no done pulse follows.
6. DIV_SIGNED_EN undefined: 0xFFFFFFFF/2 -> q=0x7FFFFFFF, r=1; latency still 33.
